// File: rtl/result_transmit_control_if.sv
// Bundles the result capture handshake and the UART TX byte handshake.
// The slave modport is the frame builder; the master modport is its environment.
interface result_transmit_control_if;
   logic        result_valid;
   logic [15:0] result;
   logic [7:0]  flags;
   logic        result_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        busy;

   modport slave (
      input  result_valid, result, flags, tx_busy,
      output result_ready, tx_data, tx_start, busy
   );

   modport master (
      output result_valid, result, flags, tx_busy,
      input  result_ready, tx_data, tx_start, busy
   );
endinterface

// File: rtl/result_transmit_control.sv
// Captures a 16-bit result plus flags and sends it to the UART TX as the
// 5-byte frame HEADER, result hi, result lo, flags, XOR checksum.
module result_transmit_control (
   input logic                      clk,
   input logic                      reset,
   result_transmit_control_if.slave bus
);
   localparam logic [7:0] HEADER   = 8'hAA;
   localparam logic [2:0] LAST_IDX = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] result_q, result_d;
   logic [7:0]  flags_q, flags_d;
   logic [7:0]  chk_q, chk_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        ready_q, ready_d;
   logic [7:0]  frame_byte_s;

   function automatic logic [7:0] frame_checksum(input logic [15:0] res,
                                                 input logic [7:0]  flg);
      return HEADER ^ res[15:8] ^ res[7:0] ^ flg;
   endfunction

   // Selects the frame byte addressed by the current index.
   always_comb begin
      frame_byte_s = 8'h00;
      case (idx_q)
         3'd0:    frame_byte_s = HEADER;
         3'd1:    frame_byte_s = result_q[15:8];
         3'd2:    frame_byte_s = result_q[7:0];
         3'd3:    frame_byte_s = flags_q;
         3'd4:    frame_byte_s = chk_q;
         default: frame_byte_s = 8'h00;
      endcase
   end

   // Next-state and next-output logic for the capture/send/hold sequence.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      result_d   = result_q;
      flags_d    = flags_q;
      chk_d      = chk_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.result_valid) begin
               result_d = bus.result;
               flags_d  = bus.flags;
               chk_d    = frame_checksum(bus.result, bus.flags);
               idx_d    = 3'd0;
               state_d  = SEND;
            end else begin
               state_d  = IDLE;
            end
         end
         SEND: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = frame_byte_s;
               state_d    = HOLD;
            end else begin
               state_d    = SEND;
            end
         end
         HOLD: begin
            // The TX raises tx_busy on this edge, so the following SEND waits for it.
            if (idx_q == LAST_IDX) begin
               idx_d   = 3'd0;
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = SEND;
            end
         end
         default: begin
            idx_d   = 3'd0;
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= 3'd0;
         result_q   <= 16'h0000;
         flags_q    <= 8'h00;
         chk_q      <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         chk_q      <= chk_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result_ready = ready_q;
   assign bus.busy         = ~ready_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_start     = tx_start_q;
endmodule

// File: tb/tb_result_transmit_control.sv
// Directed bench for result_transmit_control with a simple UART TX busy model.
module tb_result_transmit_control;
   logic clk = 1'b0;
   logic rst;
   logic ext_busy;
   int   cyc = 0;
   int   tx_len = 10;
   int   busy_cnt;
   int   wide_cnt = 0;
   logic prev_start = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   logic [7:0] bytes_q[$];
   int         starts_q[$];
   int         t0;

   always #10 clk = ~clk;

   result_transmit_control_if ifc();

   result_transmit_control dut (
      .clk   (clk),
      .reset (rst),
      .bus   (ifc.slave)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // TX model: busy for tx_len cycles starting the edge after it samples tx_start.
   always @(posedge clk) begin
      if (rst)               busy_cnt <= 0;
      else if (ifc.tx_start) busy_cnt <= tx_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign ifc.tx_busy = (busy_cnt != 0) || ext_busy;

   always @(negedge clk) begin
      if (ifc.tx_start) begin
         bytes_q.push_back(ifc.tx_data);
         starts_q.push_back(cyc);
         if (prev_start) wide_cnt++;
      end
      prev_start = ifc.tx_start;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (bytes_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check_eq(tag, bytes_q.size(), n);
   endtask

   function automatic int get_start(input int i);
      return (i < starts_q.size()) ? starts_q[i] : -1000;
   endfunction

   task automatic check_bytes(input string tag, input int base, input logic [39:0] exp);
      logic [31:0] obs;
      for (int i = 0; i < 5; i++) begin
         obs = (base + i < bytes_q.size()) ? {24'h0, bytes_q[base + i]} : 32'h100;
         check_eq($sformatf("%s[%0d]", tag, i), obs, {24'h0, exp[39 - 8*i -: 8]});
      end
   endtask

   task automatic clear();
      bytes_q.delete();
      starts_q.delete();
   endtask

   task automatic send(input logic [15:0] res, input logic [7:0] flg);
      ifc.result = res;
      ifc.flags = flg;
      ifc.result_valid = 1'b1;
      tick();
      check_eq("accept_ready_low", ifc.result_ready, 1'b0);
      ifc.result_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ext_busy = 1'b0;
      ifc.result_valid = 1'b0;
      ifc.result = 16'h0000;
      ifc.flags = 8'h00;
      repeat (3) tick();
      check_eq("rst_ready", ifc.result_ready, 1'b1);
      check_eq("rst_busy", ifc.busy, 1'b0);
      check_eq("rst_start", ifc.tx_start, 1'b0);
      check_eq("rst_data", ifc.tx_data, 8'h00);
      rst = 1'b0;
      clear();
      repeat (20) tick();
      check_eq("idle_no_start", bytes_q.size(), 0);
      check_eq("idle_ready", ifc.result_ready, 1'b1);

      // single frame
      clear();
      t0 = cyc;
      send(16'h1234, 8'h01);
      check_eq("single_busy", ifc.busy, 1'b1);
      wait_starts(5, 200, "single_count");
      check_bytes("single", 0, 40'hAA_12_34_01_8D);
      check_eq("single_latency", get_start(0) - t0, 2);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("single_gap%0d", i), get_start(i + 1) - get_start(i), 12);
      tick();
      check_eq("single_ready_back", ifc.result_ready, 1'b1);
      check_eq("single_start_low", ifc.tx_start, 1'b0);
      repeat (15) tick();

      // hold-off while TX is busy with other traffic
      clear();
      ext_busy = 1'b1;
      send(16'h0F0F, 8'h10);
      repeat (49) tick();
      check_eq("holdoff_no_start", bytes_q.size(), 0);
      ext_busy = 1'b0;
      t0 = cyc;
      wait_starts(1, 20, "holdoff_first");
      check_eq("holdoff_latency", get_start(0) - t0, 1);
      wait_starts(5, 200, "holdoff_count");
      check_bytes("holdoff", 0, 40'hAA_0F_0F_10_BA);
      repeat (15) tick();

      // back-to-back frames with result_valid held
      clear();
      send(16'hFFFF, 8'h00);
      ifc.result_valid = 1'b1;
      ifc.result = 16'h0000;
      wait_starts(5, 200, "b2b_first_count");
      tick();
      check_eq("b2b_ready_window", ifc.result_ready, 1'b1);
      tick();
      check_eq("b2b_second_accept", ifc.result_ready, 1'b0);
      ifc.result_valid = 1'b0;
      wait_starts(10, 300, "b2b_second_count");
      check_bytes("b2b_f1", 0, 40'hAA_FF_FF_00_AA);
      check_bytes("b2b_f2", 5, 40'hAA_00_00_00_AA);
      check_eq("b2b_header_wait", get_start(5) - get_start(4), 12);
      repeat (15) tick();

      // result_valid pulsed mid-frame is ignored
      clear();
      send(16'hCAFE, 8'h5A);
      wait_starts(1, 50, "ign_first");
      ifc.result = 16'hBEEF;
      ifc.result_valid = 1'b1;
      tick();
      ifc.result_valid = 1'b0;
      wait_starts(5, 200, "ign_count");
      check_bytes("ign", 0, 40'hCA_FE_5A_C4 | 40'hAA_00_00_00_00 << 0 >> 0 & 40'h0 | {8'hAA, 32'hCAFE_5AC4});
      repeat (40) tick();
      check_eq("ign_no_extra", bytes_q.size(), 5);

      // reset mid-frame after the second byte
      clear();
      send(16'h5678, 8'h00);
      wait_starts(2, 100, "rstmid_two");
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_eq("rstmid_start", ifc.tx_start, 1'b0);
      check_eq("rstmid_ready", ifc.result_ready, 1'b1);
      check_eq("rstmid_busy", ifc.busy, 1'b0);
      rst = 1'b0;
      repeat (30) tick();
      check_eq("rstmid_no_more", bytes_q.size(), 2);
      clear();
      send(16'h0102, 8'h03);
      wait_starts(5, 200, "rstmid_new_count");
      check_bytes("rstmid_new", 0, 40'hAA_01_02_03_AA);

      check_eq("start_one_cycle", wide_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
